// File: rtl/rx_uart_if.sv
// Serial-receive bundle: line and oversampling tick in, received word, done strobe and frame flags out.
interface rx_uart_if #(
    parameter int N_DATA = 8
);
    logic              rx;
    logic              s_tick;
    logic [N_DATA-1:0] dout;
    logic              rx_done_tick;
    logic              parity_err;
    logic              frame_err;

    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/rx_uart.sv
// UART receiver: start, N_DATA bits LSB first, parity, stop; 16x oversampled via s_tick.
// Latency: done strobe one clock after the stop-bit centre sample. Backpressure: none, each frame is delivered once.
module rx_uart #(
    parameter int N_DATA      = 8,
    parameter int DATA_TICKS  = 15,
    parameter int MID_TICKS   = 7,
    parameter int PARITY_MODE = 0
) (
    input  logic       clock,
    input  logic       reset,
    rx_uart_if.slave   bus
);

    localparam int              BW       = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [3:0]      TICK_END = 4'(DATA_TICKS);
    localparam logic [3:0]      TICK_MID = 4'(MID_TICKS);
    localparam logic [BW-1:0]   BIT_LAST = BW'(N_DATA - 1);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        PAR   = 5'b01000,
        STOP  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_DATA-1:0] shreg_q, shreg_d;
    logic              par_ok_q, par_ok_d;
    logic [N_DATA-1:0] dout_q, dout_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              rx_meta, rx_s;
    logic              par_xor, par_sample;

    // rx is asynchronous to clock; reset to idle-high so reset release does not look like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    assign par_xor    = ^{shreg_q, rx_s};
    assign par_sample = (PARITY_MODE == 0) ? !rx_s :
                        (PARITY_MODE == 1) ? !par_xor : par_xor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_ok_q <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_ok_q <= par_ok_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_ok_d = par_ok_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_MID) begin
                        // a start bit that is gone by its centre is treated as line noise
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shreg_d = {rx_s, shreg_q[N_DATA-1:1]};
                        if (bit_q == BIT_LAST) state_d = PAR;
                        else                   bit_d   = bit_q + BW'(1);
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d   = '0;
                        par_ok_d = par_sample;
                        state_d  = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (tick_q == TICK_END) begin
                        // frames with errors are still delivered; the flags tell the consumer
                        tick_d  = '0;
                        dout_d  = shreg_q;
                        perr_d  = !par_ok_q;
                        ferr_d  = !rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;

endmodule
